// File: rtl/spi_slave.sv
// SPI-style frame receiver: shifts a 145-bit frame from mosi while ss is low.
// Ports: clk, rst (sync, low), ss, mosi in; usr_key/addr/loc, mode, start out.
module spi_slave (
  input  logic         clk,
  input  logic         rst,
  input  logic         ss,
  input  logic         mosi,
  output logic [127:0] usr_key,
  output logic [7:0]   usr_addr,
  output logic [7:0]   usr_loc,
  output logic         mode,
  output logic         start
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [144:0] r_sr;
  logic [7:0]   r_cnt;
  logic [127:0] r_key;
  logic [7:0]   r_addr;
  logic [7:0]   r_loc;
  logic         r_mode;
  logic         r_start;

  logic [144:0] w_frame;
  logic         w_last;

  // Frame as it stands once the current mosi bit is included.
  assign w_frame = {r_sr[143:0], mosi};
  // Counter holds bits already taken, so 144 means this edge takes bit 145.
  assign w_last  = (r_cnt == 8'd144);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (!ss) w_next = SHIFT;
      SHIFT: begin
        if (ss)          w_next = IDLE;
        else if (w_last) w_next = HOLD;
      end
      HOLD:    if (ss) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sr    <= '0;
      r_cnt   <= '0;
      r_key   <= '0;
      r_addr  <= '0;
      r_loc   <= '0;
      r_mode  <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_start <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (!ss) begin
            r_sr  <= {144'd0, mosi};
            r_cnt <= 8'd1;
          end else begin
            r_cnt <= '0;
          end
        end
        SHIFT: begin
          if (ss) begin
            // Abort: drop the partial frame, outputs untouched.
            r_sr  <= '0;
            r_cnt <= '0;
          end else begin
            r_sr  <= w_frame;
            r_cnt <= r_cnt + 8'd1;
            if (w_last) begin
              r_mode  <= w_frame[144];
              r_addr  <= w_frame[143:136];
              r_loc   <= w_frame[135:128];
              r_key   <= w_frame[127:0];
              r_start <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (ss) r_cnt <= '0;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign usr_key  = r_key;
  assign usr_addr = r_addr;
  assign usr_loc  = r_loc;
  assign mode     = r_mode;
  assign start    = r_start;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: driver queues expected frames,
// a monitor pops and compares on every start pulse.
module tb_spi_slave;

  logic         clk;
  logic         rst;
  logic         ss;
  logic         mosi;
  logic [127:0] usr_key;
  logic [7:0]   usr_addr;
  logic [7:0]   usr_loc;
  logic         mode;
  logic         start;

  spi_slave dut (
    .clk      (clk),
    .rst      (rst),
    .ss       (ss),
    .mosi     (mosi),
    .usr_key  (usr_key),
    .usr_addr (usr_addr),
    .usr_loc  (usr_loc),
    .mode     (mode),
    .start    (start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [144:0] f;
    int           cyc;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           pulses = 0;
  int           exp_pulses = 0;
  logic         prev_start = 1'b0;
  logic [144:0] last_f = '0;

  function automatic logic [144:0] mk(
    input logic mo, input logic [7:0] a,
    input logic [7:0] l, input logic [127:0] k);
    return {mo, a, l, k};
  endfunction

  function automatic logic [144:0] outs();
    return {mode, usr_addr, usr_loc, usr_key};
  endfunction

  task automatic chk(input string nm,
                     input logic [144:0] act,
                     input logic [144:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every start pulse must match the head of the queue.
  always @(posedge clk) begin
    #1;
    if (start === 1'b1) begin
      exp_t e;
      pulses++;
      chk("start_single", {144'd0, prev_start}, 145'd0);
      if (q.size() == 0) begin
        chk("unexpected_start", 145'd1, 145'd0);
      end else begin
        e = q.pop_front();
        chk("frame_outputs", outs(), e.f);
        chk("frame_latency", 145'(cyc), 145'(e.cyc));
      end
    end
    prev_start = start;
  end

  task automatic send(input logic [144:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1;
      ss  = 1'b0;
      if (i < 145) mosi = f[144-i];
      else         mosi = i[0];
      if (i == 144) begin
        exp_t e;
        e.f   = f;
        e.cyc = cyc + 1;
        q.push_back(e);
        last_f = f;
        exp_pulses++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ss   = 1'b1;
      mosi = 1'($urandom_range(0, 1));
    end
  endtask

  logic [144:0] f1, fab, f3, f4, f4b, f5, f6, f7;

  initial begin
    f1  = mk(1'b1, 8'h3C, 8'hA5, 128'h000102030405060708090A0B0C0D0E0F);
    fab = mk(1'b1, 8'h55, 8'h66, 128'hFFFF0000FFFF0000FFFF0000FFFF0000);
    f3  = mk(1'b0, 8'h12, 8'h34, 128'hDEADBEEFCAFEF00D0123456789ABCDEF);
    f4  = mk(1'b1, 8'h80, 8'h7F, 128'hFEDCBA98765432100011223344556677);
    f4b = mk(1'b1, 8'hAA, 8'hBB, 128'h13579BDF2468ACE013579BDF2468ACE0);
    f5  = mk(1'b0, 8'hFF, 8'h01, {128{1'b1}});
    f6  = mk(1'b0, 8'h01, 8'h02, 128'h0F0E0D0C0B0A09080706050403020100);
    f7  = mk(1'b1, 8'hC3, 8'h5A, 128'h80000000000000000000000000000001);

    rst  = 1'b0;
    ss   = 1'b1;
    mosi = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), 145'd0);
    chk("reset_start", {144'd0, start}, 145'd0);

    send(f1, 145);
    idle(3);
    chk("f1_hold", outs(), f1);

    send(fab, 60);
    idle(3);
    chk("abort_hold", outs(), f1);

    send(f3, 145);
    idle(2);
    chk("f3_hold", outs(), f3);

    send(f4, 150);
    idle(2);
    chk("overrun_hold", outs(), f4);

    send(f4b, 100);
    @(negedge clk);
    rst    = 1'b0;
    ss     = 1'b0;
    last_f = '0;
    @(negedge clk);
    chk("midframe_reset", outs(), 145'd0);
    chk("midframe_reset_start", {144'd0, start}, 145'd0);

    send(f5, 145);
    idle(2);
    chk("f5_hold", outs(), f5);

    send(f6, 145);
    idle(1);
    send(f7, 145);
    idle(4);
    chk("b2b_hold", outs(), f7);
    chk("model_last", outs(), last_f);

    chk("queue_empty", 145'(q.size()), 145'd0);
    chk("pulse_count", 145'(pulses), 145'(exp_pulses));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
